sea_round_ctrl: RTL and testbench
=================================

SEA_ROUND_CTRL -- requirements
Module: sea_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 52: number of SEA rounds; even, 4..62.
REQ-002 SHALL have parameter W, default 48: half-block width in bits.
REQ-003 SHALL use one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ena  in  1  global enable; low stalls all state changes except reset.
REQ-007 start  in  1  request one block operation; sampled only in IDLE.
REQ-008 mode  in  1  0 = encrypt, 1 = decrypt; latched on start acceptance.
REQ-009 din_l, din_r  in  W  input half-blocks; latched on start acceptance.
REQ-010 rf_l, rf_r  in  W  round result from the external combinational round datapath.
REQ-011 st_l, st_r  out  W  current state to the datapath; result when done=1.
REQ-012 rnd_idx  out  6  current round index.
REQ-013 rnd_en  out  1  high when the round in progress commits at this edge.
REQ-014 key_turn  out  1  key-schedule turn strobe to the datapath.
REQ-015 mode_q  out  1  latched mode.
REQ-016 busy  out  1  high in RUN and DONE.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 IDLE with start=1 and ena=1: st_l<=din_l, st_r<=din_r, mode_q<=mode, rnd_idx<=0 (encrypt) or NR-1 (decrypt), next state RUN.
REQ-020 RUN with ena=1: rnd_en=1, st_l<=rf_l, st_r<=rf_r, rnd_idx steps +1 (encrypt) or -1 (decrypt).
REQ-021 RUN with ena=0: rnd_en=0; st, rnd_idx and state frozen.
REQ-022 After the NR-th committed round, next state SHALL be DONE; rnd_idx SHALL not wrap, and holds its last round value in DONE.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE regardless of ena.
REQ-024 Latency: with no stalls, done SHALL be high in the cycle following the NR-th edge after the start-acceptance edge; each ena-low cycle in RUN SHALL add exactly one cycle.
REQ-025 key_turn SHALL be high iff state=RUN and rnd_idx == NR/2, in both modes.
REQ-026 start SHALL be ignored in RUN and DONE, with no queueing.
REQ-027 st_l/st_r SHALL hold the result after DONE until the next start is accepted.
REQ-028 rnd_en, key_turn and done SHALL be 0 outside the states named for them above.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE and all outputs and registers to 0, including st_l, st_r, rnd_idx and mode_q.
REQ-030 Reset mid-operation SHALL discard the block with no done pulse.
REQ-031 First start acceptance SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-032 Macro SEA_CTRL_ABORT_EN SHALL gate an abort feature.
REQ-033 With SEA_CTRL_ABORT_EN defined: an input port abort (1 bit) SHALL exist. abort=1 in RUN or DONE moves to IDLE at the next edge regardless of ena; st_l, st_r and rnd_idx clear to 0; no done pulse. abort in IDLE has no effect, and abort wins over start in the same cycle.
REQ-034 Without SEA_CTRL_ABORT_EN: the abort port SHALL be absent and behaviour SHALL be as REQ-018..REQ-031.

Verification (NR=8, datapath model rf_l=st_r, rf_r=st_l)
REQ-035 Encrypt start, din_l=0x123456789ABC, din_r=0xFEDCBA987654 -> rnd_idx 0..7, done 8 cycles after acceptance, st_l=0x123456789ABC, st_r=0xFEDCBA987654.
REQ-036 Same block with ena low for 3 cycles at rnd_idx=2 -> rnd_idx holds 2 and rnd_en=0 for those cycles; done 3 cycles later; identical result.
REQ-037 Decrypt start -> rnd_idx 7,6,...,0; key_turn high exactly one cycle, at rnd_idx=4; mode_q=1.
REQ-038 start held high throughout a run -> second block accepted only in the IDLE cycle after the done pulse; exactly one done per block.
REQ-039 rst_n low at rnd_idx=3 -> busy=0, st_l=st_r=0 and rnd_idx=0 immediately; no done pulse.
REQ-040 With SEA_CTRL_ABORT_EN: abort at rnd_idx=5 -> IDLE next edge, no done pulse; a following start completes normally.

Source files
------------

// File: rtl/sea_round_ctrl.sv
// ---------------------------------------------------------------------------
// sea_round_ctrl
//
// Round sequencer for an iterative SEA block cipher core. Holds the two
// half-block state registers, steps the round index up (encrypt) or down
// (decrypt), and tells the external combinational round datapath when a round
// commits and when the key schedule turns. Commits one round per enabled clock.
//
// Parameters
//   NR : number of rounds (even, 4..62)
//   W  : half-block width in bits
//
// Ports
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   ena            in   global enable; low freezes everything except reset
//   start          in   request one block; only looked at in IDLE
//   mode           in   0 = encrypt, 1 = decrypt; latched on acceptance
//   abort          in   (only with SEA_CTRL_ABORT_EN) drop the current block
//   din_l, din_r   in   input half-blocks; latched on acceptance
//   rf_l, rf_r     in   round result from the external datapath
//   st_l, st_r     out  current state to the datapath; result when done=1
//   rnd_idx        out  current round index
//   rnd_en         out  high when the round in progress commits at this edge
//   key_turn       out  key-schedule turn strobe (RUN and rnd_idx == NR/2)
//   mode_q         out  latched mode
//   busy           out  high in RUN and DONE
//   done           out  one-cycle completion pulse
//
// Optional feature
//   Define SEA_CTRL_ABORT_EN to add the abort input. Without it the port is
//   absent and abort is tied off internally.
// ---------------------------------------------------------------------------
module sea_round_ctrl #(
  parameter int NR = 52,
  parameter int W  = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic         mode,
`ifdef SEA_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic [W-1:0] din_l,
  input  logic [W-1:0] din_r,
  input  logic [W-1:0] rf_l,
  input  logic [W-1:0] rf_r,
  output logic [W-1:0] st_l,
  output logic [W-1:0] st_r,
  output logic [5:0]   rnd_idx,
  output logic         rnd_en,
  output logic         key_turn,
  output logic         mode_q,
  output logic         busy,
  output logic         done
);

  localparam logic [5:0] LAST_IDX = 6'(NR - 1);
  localparam logic [5:0] HALF_IDX = 6'(NR / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [W-1:0]   r_st_l;
  logic [W-1:0]   r_st_r;
  logic [5:0]     r_rnd_idx;
  logic           r_mode_q;

  logic [W-1:0]   w_st_l_next;
  logic [W-1:0]   w_st_r_next;
  logic [5:0]     w_rnd_idx_next;
  logic           w_mode_q_next;

  logic           w_abort;
  logic           w_abort_act;
  logic           w_accept;
  logic           w_commit;
  logic           w_last_round;

`ifdef SEA_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only acts on a block in flight; in IDLE it merely blocks a
  // simultaneous start so that abort always wins.
  assign w_abort_act = w_abort && (r_state != S_IDLE);
  assign w_accept    = (r_state == S_IDLE) && start && ena && !w_abort;
  assign w_commit    = (r_state == S_RUN) && ena && !w_abort;

  // The round index itself tells us which round is last, so no separate
  // round counter is needed: encrypt ends at NR-1, decrypt ends at 0.
  assign w_last_round = r_mode_q ? (r_rnd_idx == 6'd0) : (r_rnd_idx == LAST_IDX);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (ena && w_last_round) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // DONE always lasts one cycle, enabled or not.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  always_comb begin
    rnd_en   = w_commit;
    key_turn = (r_state == S_RUN) && (r_rnd_idx == HALF_IDX);
    busy     = (r_state != S_IDLE);
    // An abort landing on the DONE cycle suppresses the pulse as well.
    done     = (r_state == S_DONE) && !w_abort;
  end

  // -------------------------------------------------------------------------
  // Datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_st_l_next    = r_st_l;
    w_st_r_next    = r_st_r;
    w_rnd_idx_next = r_rnd_idx;
    w_mode_q_next  = r_mode_q;

    if (w_accept) begin
      w_st_l_next    = din_l;
      w_st_r_next    = din_r;
      w_mode_q_next  = mode;
      w_rnd_idx_next = mode ? LAST_IDX : 6'd0;
    end else if (w_abort_act) begin
      w_st_l_next    = '0;
      w_st_r_next    = '0;
      w_rnd_idx_next = 6'd0;
    end else if (w_commit) begin
      w_st_l_next = rf_l;
      w_st_r_next = rf_r;
      // The index parks on the final round value instead of wrapping.
      if (!w_last_round) begin
        w_rnd_idx_next = r_mode_q ? (r_rnd_idx - 6'd1) : (r_rnd_idx + 6'd1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_l    <= '0;
      r_st_r    <= '0;
      r_rnd_idx <= 6'd0;
      r_mode_q  <= 1'b0;
    end else begin
      r_st_l    <= w_st_l_next;
      r_st_r    <= w_st_r_next;
      r_rnd_idx <= w_rnd_idx_next;
      r_mode_q  <= w_mode_q_next;
    end
  end

  assign st_l    = r_st_l;
  assign st_r    = r_st_r;
  assign rnd_idx = r_rnd_idx;
  assign mode_q  = r_mode_q;

endmodule

// File: tb/tb_sea_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sea_round_ctrl
//
// Bench for sea_round_ctrl with NR=8, W=48. The external datapath is a swap
// (rf_l = st_r, rf_r = st_l), optionally with the round index XORed into the
// right half so that round order and round count show up in the result.
// Expected results are queued when a block is started and checked when done
// pulses. Define SEA_CTRL_ABORT_EN to also exercise the abort path.
// ---------------------------------------------------------------------------
module tb_sea_round_ctrl;

  localparam int NR = 8;
  localparam int W  = 48;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         ena    = 1'b0;
  logic         start  = 1'b0;
  logic         mode   = 1'b0;
  logic [W-1:0] din_l  = '0;
  logic [W-1:0] din_r  = '0;
  logic [W-1:0] rf_l;
  logic [W-1:0] rf_r;
  logic [W-1:0] st_l;
  logic [W-1:0] st_r;
  logic [5:0]   rnd_idx;
  logic         rnd_en;
  logic         key_turn;
  logic         mode_q;
  logic         busy;
  logic         done;
  logic         dp_mix = 1'b0;
`ifdef SEA_CTRL_ABORT_EN
  logic         abort  = 1'b0;
`endif

  sea_round_ctrl #(.NR(NR), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .mode     (mode),
`ifdef SEA_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .din_l    (din_l),
    .din_r    (din_r),
    .rf_l     (rf_l),
    .rf_r     (rf_r),
    .st_l     (st_l),
    .st_r     (st_r),
    .rnd_idx  (rnd_idx),
    .rnd_en   (rnd_en),
    .key_turn (key_turn),
    .mode_q   (mode_q),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Round datapath model.
  assign rf_l = st_r;
  assign rf_r = st_l ^ (dp_mix ? {{(W-6){1'b0}}, rnd_idx} : {W{1'b0}});

  int checks     = 0;
  int errors     = 0;
  int done_count = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  typedef struct {
    logic         mode;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic         mix;
    int           stall_at;   // committed-round count at which to stall, -1 = none
    int           stall_len;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
  } rec_t;

  rec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: NR rounds of the datapath model, index order set by mode.
  function automatic logic [2*W-1:0] model(input logic md, input logic [W-1:0] l,
                                           input logic [W-1:0] r, input logic mix);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] t;
    int idx;
    a = l;
    b = r;
    for (int k = 0; k < NR; k++) begin
      idx = md ? (NR - 1 - k) : k;
      t = a;
      a = b;
      b = t ^ (mix ? W'(idx) : {W{1'b0}});
    end
    return {a, b};
  endfunction

  // Scoreboard: every done pulse must match the oldest queued block.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending block at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_l", 64'(st_l), 64'(mon_e[2*W-1:W]));
        chk("result_r", 64'(st_r), 64'(mon_e[W-1:0]));
        $display("block done: st_l=0x%012h st_r=0x%012h", st_l, st_r);
      end
    end
  end

  // Waits (bounded) for done from the negedge after acceptance; checks latency.
  task automatic wait_done(input string name, input int exp_cyc);
    int cnt;
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, 64'(cnt), 64'(exp_cyc));
  endtask

  // Runs one table record with per-cycle checks of the round sequence.
  task automatic run_block(input rec_t v, input int n);
    int cyc;
    int k;
    int stalled;
    int exp_idx;
    int d0;
    logic got_done;
    d0 = done_count;
    @(negedge clk);
    chk("idle_before", 64'(busy), 64'd0);
    mode   = v.mode;
    din_l  = v.l;
    din_r  = v.r;
    dp_mix = v.mix;
    ena    = 1'b1;
    start  = 1'b1;
    exp_q.push_back({v.exp_l, v.exp_r});
    @(negedge clk);
    start = 1'b0;
    // Disturb the inputs: only the values latched at acceptance may matter.
    din_l = ~v.l;
    din_r = ~v.r;
    mode  = ~v.mode;
    chk("mode_q", 64'(mode_q), 64'(v.mode));
    cyc = 0;
    k = 0;
    stalled = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        exp_idx = v.mode ? (NR - 1 - k) : k;
        chk("busy_run", 64'(busy), 64'd1);
        chk("rnd_idx", 64'(rnd_idx), 64'(exp_idx));
        if (k == v.stall_at && stalled < v.stall_len) begin
          ena = 1'b0;
          stalled++;
        end else begin
          ena = 1'b1;
        end
        #1;
        chk("rnd_en", 64'(rnd_en), 64'(ena));
        chk("key_turn", 64'(key_turn), 64'(exp_idx == NR / 2));
        if (ena) k++;
        cyc++;
        @(negedge clk);
      end
    end
    ena = 1'b1;
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles (block %0d)", n);
    end else begin
      chk("latency", 64'(cyc), 64'(NR + v.stall_len));
      chk("idx_final", 64'(rnd_idx), 64'(v.mode ? 0 : NR - 1));
      chk("key_turn_done", 64'(key_turn), 64'd0);
    end
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_once", 64'(done_count - d0), 64'd1);
    repeat (2) @(negedge clk);
    chk("hold_l", 64'(st_l), 64'(v.exp_l));
    chk("hold_r", 64'(st_r), 64'(v.exp_r));
    $display("block %0d: mode=%0d mix=%0d stalls=%0d cycles=%0d", n, v.mode, v.mix, v.stall_len, cyc);
  endtask

  initial begin
    logic [W-1:0] a_l;
    logic [W-1:0] a_r;
    logic [W-1:0] b_l;
    logic [W-1:0] b_r;
    int d0;
    int cnt;
    logic [2*W-1:0] m;

    a_l = 48'h123456789ABC;
    a_r = 48'hFEDCBA987654;
    b_l = 48'h0F1E2D3C4B5A;
    b_r = 48'hA5A55A5A0001;

    tbl[0] = '{1'b0, a_l, a_r, 1'b0, -1, 0, a_l, a_r};
    tbl[1] = '{1'b0, a_l, a_r, 1'b0,  2, 3, a_l, a_r};
    tbl[2] = '{1'b1, a_l, a_r, 1'b0, -1, 0, a_l, a_r};
    tbl[3] = '{1'b0, b_l, b_r, 1'b1, -1, 0, '0, '0};
    tbl[4] = '{1'b1, b_l, b_r, 1'b1,  5, 2, '0, '0};
    tbl[5] = '{1'b1, a_l, b_r, 1'b0,  0, 1, a_l, b_r};
    for (int i = 3; i < 5; i++) begin
      m = model(tbl[i].mode, tbl[i].l, tbl[i].r, tbl[i].mix);
      tbl[i].exp_l = m[2*W-1:W];
      tbl[i].exp_r = m[W-1:0];
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_st_l", 64'(st_l), 64'd0);
    chk("rst_st_r", 64'(st_r), 64'd0);
    chk("rst_idx", 64'(rnd_idx), 64'd0);
    chk("rst_mode_q", 64'(mode_q), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rnd_en", 64'(rnd_en), 64'd0);
    chk("rst_key_turn", 64'(key_turn), 64'd0);
    rst_n = 1'b1;

    // start with ena low in IDLE is not accepted
    @(negedge clk);
    start = 1'b1;
    ena   = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ena_low", 64'(busy), 64'd0);
    start = 1'b0;
    ena   = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_block(tbl[i], i);
    end

    // start held high through a whole block: second block only after DONE
    d0 = done_count;
    @(negedge clk);
    mode   = 1'b0;
    dp_mix = 1'b1;
    din_l  = b_l;
    din_r  = b_r;
    start  = 1'b1;
    exp_q.push_back(model(1'b0, b_l, b_r, 1'b1));
    @(negedge clk);
    chk("held_busy1", 64'(busy), 64'd1);
    din_l = a_l;
    din_r = b_l;
    exp_q.push_back(model(1'b0, a_l, b_l, 1'b1));
    wait_done("held_lat1", NR);
    @(negedge clk);
    chk("held_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    chk("held_busy2", 64'(busy), 64'd1);
    chk("held_idx2", 64'(rnd_idx), 64'd0);
    start = 1'b0;
    wait_done("held_lat2", NR);
    @(negedge clk);
    chk("held_done_cnt", 64'(done_count - d0), 64'd2);
    $display("held-start sequence: dones=%0d", done_count - d0);

    // reset in the middle of a block
    d0 = done_count;
    @(negedge clk);
    mode   = 1'b0;
    dp_mix = 1'b0;
    din_l  = a_l;
    din_r  = a_r;
    start  = 1'b1;
    exp_q.push_back({a_l, a_r});
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (rnd_idx !== 6'd3 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst_mid_reach", 64'(rnd_idx), 64'd3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_st_l", 64'(st_l), 64'd0);
    chk("rst_mid_st_r", 64'(st_r), 64'd0);
    chk("rst_mid_idx", 64'(rnd_idx), 64'd0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", 64'(busy), 64'd0);
    chk("rst_no_done", 64'(done_count - d0), 64'd0);
    exp_q.push_back({a_l, a_r});
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_accept", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done("post_rst_lat", NR);
    @(negedge clk);
    $display("reset sequence: dones=%0d", done_count - d0);

`ifdef SEA_CTRL_ABORT_EN
    // abort in the middle of a block
    d0 = done_count;
    @(negedge clk);
    mode   = 1'b0;
    dp_mix = 1'b0;
    din_l  = b_l;
    din_r  = b_r;
    start  = 1'b1;
    exp_q.push_back({b_l, b_r});
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (rnd_idx !== 6'd5 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_reach", 64'(rnd_idx), 64'd5);
    abort = 1'b1;
    ena   = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    ena   = 1'b1;
    exp_q.delete();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_st_l", 64'(st_l), 64'd0);
    chk("abort_idx", 64'(rnd_idx), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_count - d0), 64'd0);
    run_block(tbl[3], 10);
    $display("abort sequence: dones=%0d", done_count - d0);
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
